majority_checker: RTL and testbench

- Synthesizable self-test engine for the 3-input majority gate (Majority: inputs A, B, C; output Y).
- On a start pulse it drives all 8 input vectors onto the DUT, waits a settle interval, samples Y and compares it against a golden majority function.
- Reports pass/fail, a mismatch count and the first failing vector, so the lab board can self-check the gate without a simulator.
- Sits beside the Majority instance in the board top level; outputs go to LEDs.

---
 rtl/majority_pkg.sv | 20 ++
 rtl/majority_ref.sv | 13 +
 rtl/majority_checker.sv | 136 +++++++++++++
 tb/tb_majority_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/majority_pkg.sv
// Shared definitions for the majority-gate self-test engine: FSM states,
// sweep size and the golden majority function.
package majority_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int         NUM_VECTORS = 8;
   localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

   // Golden 3-input majority: high when at least two inputs are high.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/majority_ref.sv
// Combinational golden model of the 3-input majority gate.
module majority_ref
   import majority_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic y_o
);

   assign y_o = majority3(a_i, b_i, c_i);

endmodule

// File: rtl/majority_checker.sv
// Self-test engine for a 3-input majority gate. On start it sweeps all eight
// input vectors, holds each for SETTLE_CYCLES, samples y once and compares it
// against the golden model, then reports pass, mismatch count and the first
// failing vector until the next start or reset.
module majority_checker
   import majority_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] vec_q, vec_d;
   logic [7:0] settle_q, settle_d;
   logic [2:0] abc_q, abc_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] err_q, err_d;
   logic [2:0] ff_q, ff_d;
   logic       y_exp;

   // Expected y is taken from the registered vector currently on the gate.
   majority_ref u_ref (
      .a_i (abc_q[2]),
      .b_i (abc_q[1]),
      .c_i (abc_q[0]),
      .y_o (y_exp)
   );

   // Next-state and result logic; every register holds unless told otherwise.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      abc_d    = abc_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      ff_d     = ff_q;

      case (state_q)
         IDLE, DONE: begin
            // A new sweep clears results and starts driving vector 0.
            if (start) begin
               state_d  = DRIVE;
               vec_d    = 3'd0;
               abc_d    = 3'd0;
               settle_d = 8'd0;
               err_d    = 4'd0;
               ff_d     = 3'd0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
            end
         end
         DRIVE: begin
            abc_d    = vec_q;
            settle_d = settle_q + 8'd1;
            if (settle_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            if (y != y_exp) begin
               err_d = err_q + 4'd1;
               if (err_q == 4'd0) begin
                  ff_d = vec_q;
               end
            end
            if (vec_q == LAST_VEC) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == 4'd0);
            end else begin
               state_d  = DRIVE;
               vec_d    = vec_q + 3'd1;
               abc_d    = vec_q + 3'd1;
               settle_d = 8'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers with synchronous reset clearing everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         vec_q    <= 3'd0;
         settle_q <= 8'd0;
         abc_q    <= 3'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 4'd0;
         ff_q     <= 3'd0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         abc_q    <= abc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         ff_q     <= ff_d;
      end
   end

   assign a          = abc_q[2];
   assign b          = abc_q[1];
   assign c          = abc_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule

// File: tb/tb_majority_checker.sv
// Directed testbench for majority_checker: emulates good and faulty gates on
// y and checks sweep timing, result registers, reset and start handling.
module tb_majority_checker;

   logic       clk;
   logic       reset;
   logic       start;
   logic       y;
   logic       a, b, c;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] first_fail;

   // 0: correct majority, 1: stuck at 0, 2: 3-input OR, 3: inverted majority
   logic [1:0] dut_mode;

   int checks;
   int errors;

   logic [2:0] abc_log [0:31];
   logic       busy0;
   logic       done0;
   logic [3:0] err0;
   logic [2:0] ff0;

   majority_checker #(.SETTLE_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .y          (y),
      .a          (a),
      .b          (b),
      .c          (c),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      y = 1'b0;
      case (dut_mode)
         2'd0: y = (a & b) | (b & c) | (a & c);
         2'd1: y = 1'b0;
         2'd2: y = a | b | c;
         2'd3: y = ~((a & b) | (b & c) | (a & c));
         default: y = 1'b0;
      endcase
   end

   // Pulse start, then count edges until done (bounded). Optionally re-pulse
   // start k edges after the start edge.
   task automatic run_sweep(input int repulse, output int cyc);
      int k;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abc_log[0] = {a, b, c};
      busy0 = busy;
      done0 = done;
      err0  = err_count;
      ff0   = first_fail;
      k = 0;
      while (!done && k < 100) begin
         @(posedge clk);
         #1;
         k++;
         start = (k == repulse);
         if (k < 32) abc_log[k] = {a, b, c};
      end
      start = 1'b0;
      cyc = k;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({a, b, c, busy, done, pass, err_count, first_fail} !== 13'd0) begin
         errors++;
         $display("FAIL reset_state got %b want 0", {a, b, c, busy, done, pass, err_count, first_fail});
      end
      $display("reset: outputs=%b", {a, b, c, busy, done, pass, err_count, first_fail});
   endtask

   task automatic test_correct();
      int cyc;
      dut_mode = 2'd0;
      run_sweep(-1, cyc);
      checks++;
      if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy0); end
      checks++;
      if (cyc !== 24) begin errors++; $display("FAIL done_latency got %0d want 24", cyc); end
      checks++;
      if (pass !== 1'b1) begin errors++; $display("FAIL correct_pass got %b want 1", pass); end
      checks++;
      if (err_count !== 4'd0) begin errors++; $display("FAIL correct_err got %0d want 0", err_count); end
      checks++;
      if (first_fail !== 3'd0) begin errors++; $display("FAIL correct_ff got %0d want 0", first_fail); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", busy); end
      for (int v = 0; v < 8; v++) begin
         checks++;
         if (abc_log[3 * v] !== 3'(v)) begin
            errors++;
            $display("FAIL abc_step%0d got %b want %b", v, abc_log[3 * v], 3'(v));
         end
      end
      checks++;
      if ({a, b, c} !== 3'b111) begin errors++; $display("FAIL abc_hold got %b want 111", {a, b, c}); end
      $display("correct: cycles=%0d pass=%b err=%0d ff=%0d", cyc, pass, err_count, first_fail);
   endtask

   task automatic test_faults();
      logic [1:0] modes    [0:2];
      logic [3:0] exp_err  [0:2];
      logic [2:0] exp_ff   [0:2];
      int cyc;
      modes[0] = 2'd1; exp_err[0] = 4'd4; exp_ff[0] = 3'd3;
      modes[1] = 2'd2; exp_err[1] = 4'd3; exp_ff[1] = 3'd1;
      modes[2] = 2'd3; exp_err[2] = 4'd8; exp_ff[2] = 3'd0;
      for (int i = 0; i < 3; i++) begin
         dut_mode = modes[i];
         run_sweep(-1, cyc);
         checks++;
         if (cyc !== 24) begin errors++; $display("FAIL fault%0d_latency got %0d want 24", i, cyc); end
         checks++;
         if (err_count !== exp_err[i]) begin
            errors++; $display("FAIL fault%0d_err got %0d want %0d", i, err_count, exp_err[i]);
         end
         checks++;
         if (first_fail !== exp_ff[i]) begin
            errors++; $display("FAIL fault%0d_ff got %0d want %0d", i, first_fail, exp_ff[i]);
         end
         checks++;
         if (pass !== 1'b0) begin errors++; $display("FAIL fault%0d_pass got %b want 0", i, pass); end
         $display("fault mode %0d: err=%0d ff=%0d pass=%b", modes[i], err_count, first_fail, pass);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      dut_mode = 2'd0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      checks++;
      if ({a, b, c} !== 3'b100) begin errors++; $display("FAIL mid_vec got %b want 100", {a, b, c}); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({a, b, c, busy, done, pass, err_count, first_fail} !== 13'd0) begin
         errors++;
         $display("FAIL mid_reset got %b want 0", {a, b, c, busy, done, pass, err_count, first_fail});
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", busy); end
      run_sweep(-1, cyc);
      checks++;
      if (cyc !== 24 || pass !== 1'b1) begin
         errors++; $display("FAIL sweep_after_reset got cyc=%0d pass=%b want 24/1", cyc, pass);
      end
      $display("reset mid-sweep: then cycles=%0d pass=%b", cyc, pass);
   endtask

   task automatic test_back_to_back();
      int cyc;
      dut_mode = 2'd3;
      run_sweep(10, cyc);
      checks++;
      if (cyc !== 24) begin errors++; $display("FAIL repulse_latency got %0d want 24", cyc); end
      checks++;
      if (err_count !== 4'd8) begin errors++; $display("FAIL repulse_err got %0d want 8", err_count); end
      dut_mode = 2'd0;
      run_sweep(-1, cyc);
      checks++;
      if ({err0, ff0, done0, busy0} !== {4'd0, 3'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL restart_clear got err=%0d ff=%0d done=%b busy=%b want 0/0/0/1", err0, ff0, done0, busy0);
      end
      checks++;
      if (cyc !== 24 || pass !== 1'b1 || err_count !== 4'd0) begin
         errors++;
         $display("FAIL restart_sweep got cyc=%0d pass=%b err=%0d want 24/1/0", cyc, pass, err_count);
      end
      $display("back-to-back: cycles=%0d pass=%b err=%0d", cyc, pass, err_count);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      dut_mode = 2'd0;
      reset    = 1'b1;
      start    = 1'b0;
      test_reset();
      test_correct();
      test_faults();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
